// File: rtl/mem_request_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data access.
// One registered grant at a time, alternating on ties, with timeout and sticky error.
module mem_request_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   input  logic              halt,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              merr,
   output logic              halted
);

   // state  | meaning
   // IDLE   | no grant; arbitrate pending requests or halt
   // IGRANT | fetch owns the RAM, waiting for ACCESS
   // DGRANT | data access owns the RAM, waiting for ACCESS
   // ERR    | RAM error or timeout seen; terminal until reset
   // HALTED | quiesced after halt; terminal until reset
   typedef enum logic [2:0] {IDLE, IGRANT, DGRANT, ERR, HALTED} state_t;

   localparam logic [1:0] RAM_ACCESS  = 2'd2;
   localparam logic [1:0] RAM_ERROR   = 2'd3;
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       last_data, last_data_nxt;
   logic       dreq;

   assign dreq = dREN | dWEN;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         last_data <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         last_data <= last_data_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      last_data_nxt = last_data;
      ramREN        = 1'b0;
      ramWEN        = 1'b0;
      ramaddr       = '0;
      ramstore      = '0;
      ihit          = 1'b0;
      iload         = '0;
      dhit          = 1'b0;
      dload         = '0;
      merr          = 1'b0;
      halted        = 1'b0;

      case (state)
         IDLE: begin
            wait_cnt_nxt = '0;
            if (dreq && iREN)
               state_nxt = last_data ? IGRANT : DGRANT;
            else if (dreq)
               state_nxt = DGRANT;
            else if (iREN && !halt)
               state_nxt = IGRANT;
            else if (halt)
               state_nxt = HALTED;
         end

         IGRANT: begin
            // a dropped request releases the RAM without a hit
            if (!iREN) begin
               state_nxt = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ramstate == RAM_ERROR) begin
                  state_nxt = ERR;
               end else if (ramstate == RAM_ACCESS) begin
                  ihit          = 1'b1;
                  iload         = ramload;
                  last_data_nxt = 1'b0;
                  state_nxt     = IDLE;
               end else if (wait_cnt == TIMEOUT_CNT) begin
                  state_nxt = ERR;
               end else begin
                  wait_cnt_nxt = wait_cnt + 8'd1;
               end
            end
         end

         DGRANT: begin
            if (!dreq) begin
               state_nxt = IDLE;
            end else begin
               ramWEN   = dWEN;
               ramREN   = !dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ramstate == RAM_ERROR) begin
                  state_nxt = ERR;
               end else if (ramstate == RAM_ACCESS) begin
                  dhit          = 1'b1;
                  dload         = ramload;
                  last_data_nxt = 1'b1;
                  state_nxt     = IDLE;
               end else if (wait_cnt == TIMEOUT_CNT) begin
                  state_nxt = ERR;
               end else begin
                  wait_cnt_nxt = wait_cnt + 8'd1;
               end
            end
         end

         ERR:     merr   = 1'b1;
         HALTED:  halted = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_request_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          iREN, dREN, dWEN, halt;
   logic [AW-1:0] iaddr, daddr;
   logic [DW-1:0] dstore, ramload;
   logic [1:0]    ramstate;
   logic          ramREN, ramWEN, ihit, dhit, merr, halted;
   logic [AW-1:0] ramaddr;
   logic [DW-1:0] ramstore, iload, dload;

   int checks = 0;
   int errors = 0;

   // model: who owns the RAM (0 nobody, 1 fetch, 2 data), cycles waited so far,
   // whether the last completed access was data, and the two terminal conditions
   int m_owner, n_owner, m_wait, n_wait;
   bit m_last_data, n_last_data, m_err, n_err, m_halt, n_halt;
   bit e_ramREN, e_ramWEN, e_ihit, e_dhit, e_merr, e_halted, e_addr_ok, e_store_ok;
   logic [AW-1:0] e_ramaddr;
   logic [DW-1:0] e_ramstore, e_iload, e_dload;

   mem_request_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .halt(halt), .ramload(ramload), .ramstate(ramstate),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload), .merr(merr), .halted(halted)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_wait = 0; m_last_data = 1'b0; m_err = 1'b0; m_halt = 1'b0;
   endtask

   function automatic void model_eval();
      bit dreq, req;
      dreq = dREN | dWEN;
      n_owner = m_owner; n_wait = m_wait; n_last_data = m_last_data;
      n_err = m_err; n_halt = m_halt;
      e_ramREN = 0; e_ramWEN = 0; e_ihit = 0; e_dhit = 0; e_merr = 0; e_halted = 0;
      e_addr_ok = 0; e_store_ok = 0; e_ramaddr = '0; e_ramstore = '0; e_iload = '0; e_dload = '0;
      if (m_err) e_merr = 1;
      else if (m_halt) e_halted = 1;
      else if (m_owner == 0) begin
         n_wait = 0;
         if (dreq && iREN) n_owner = m_last_data ? 1 : 2;
         else if (dreq) n_owner = 2;
         else if (iREN && !halt) n_owner = 1;
         else if (halt) n_halt = 1;
      end else begin
         req = (m_owner == 2) ? dreq : iREN;
         if (!req) n_owner = 0;
         else begin
            e_addr_ok = 1;
            if (m_owner == 2) begin
               e_store_ok = 1; e_ramaddr = daddr; e_ramstore = dstore;
               e_ramWEN = dWEN; e_ramREN = !dWEN;
            end else begin
               e_ramaddr = iaddr; e_ramREN = 1;
            end
            if (ramstate == 2'd3) begin
               n_err = 1; n_owner = 0;
            end else if (ramstate == 2'd2) begin
               if (m_owner == 2) begin e_dhit = 1; e_dload = ramload; end
               else begin e_ihit = 1; e_iload = ramload; end
               n_last_data = (m_owner == 2);
               n_owner = 0;
            end else if (m_wait == TO) begin
               n_err = 1; n_owner = 0;
            end else n_wait = m_wait + 1;
         end
      end
   endfunction

   task automatic step(input string tag);
      #1;
      model_eval();
      chk({tag, ".ramREN"}, 32'(ramREN), 32'(e_ramREN));
      chk({tag, ".ramWEN"}, 32'(ramWEN), 32'(e_ramWEN));
      chk({tag, ".ihit"},   32'(ihit),   32'(e_ihit));
      chk({tag, ".dhit"},   32'(dhit),   32'(e_dhit));
      chk({tag, ".iload"},  iload,       e_iload);
      chk({tag, ".dload"},  dload,       e_dload);
      chk({tag, ".merr"},   32'(merr),   32'(e_merr));
      chk({tag, ".halted"}, 32'(halted), 32'(e_halted));
      if (e_addr_ok)  chk({tag, ".ramaddr"},  ramaddr,  e_ramaddr);
      if (e_store_ok) chk({tag, ".ramstore"}, ramstore, e_ramstore);
   endtask

   task automatic tick();
      @(posedge CLK);
      m_owner = n_owner; m_wait = n_wait; m_last_data = n_last_data;
      m_err = n_err; m_halt = n_halt;
      @(negedge CLK);
   endtask

   task automatic zero_inputs();
      iREN = 0; dREN = 0; dWEN = 0; halt = 0; iaddr = '0; daddr = '0;
      dstore = '0; ramload = '0; ramstate = 2'd0;
   endtask

   task automatic do_reset();
      zero_inputs();
      nRST = 1'b0;
      model_reset();
      #1;
      chk("rst.ramREN", 32'(ramREN), 0);
      chk("rst.ramWEN", 32'(ramWEN), 0);
      chk("rst.ihit", 32'(ihit), 0);
      chk("rst.dhit", 32'(dhit), 0);
      chk("rst.merr", 32'(merr), 0);
      chk("rst.halted", 32'(halted), 0);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      int term_cnt;
      bit clr_i, clr_d;
      int r;
      zero_inputs();
      nRST = 1'b0;

      // fetch, single-cycle ACCESS
      do_reset();
      iREN = 1; iaddr = 32'h0000_0040; ramstate = 2'd2; ramload = 32'h3C01_0004;
      step("s1c1"); chk("s1c1.ihit_low", 32'(ihit), 0); tick();
      step("s1c2");
      chk("s1c2.ramREN", 32'(ramREN), 1); chk("s1c2.ramaddr", ramaddr, 32'h40);
      chk("s1c2.ihit", 32'(ihit), 1); chk("s1c2.iload", iload, 32'h3C01_0004);
      tick(); iREN = 0;
      step("s1c3"); chk("s1c3.bubble", 32'(ihit), 0); tick();

      // simultaneous fetch and write: data first, then alternate
      do_reset();
      iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
      ramstate = 2'd2; ramload = 32'h1234_5678;
      for (int c = 1; c <= 8; c++) begin
         step($sformatf("s2c%0d", c));
         if (c == 2) begin
            chk("s2.wen", 32'(ramWEN), 1); chk("s2.waddr", ramaddr, 32'h80);
            chk("s2.dhit", 32'(dhit), 1);
         end
         if (c == 4) chk("s2.ihit", 32'(ihit), 1);
         if (c == 6) chk("s2.dhit2", 32'(dhit), 1);
         tick();
      end

      // read with BUSY wait, then timeout into ERR
      do_reset();
      dREN = 1; daddr = 32'h100; ramstate = 2'd1; ramload = 32'hCAFE_0001;
      step("s3c1"); tick();
      for (int c = 0; c < 3; c++) begin step("s3busy"); tick(); end
      ramstate = 2'd2;
      step("s3acc"); chk("s3.dhit", 32'(dhit), 1); chk("s3.dload", dload, 32'hCAFE_0001);
      chk("s3.merr", 32'(merr), 0); tick();
      ramstate = 2'd1;
      step("s3idle"); tick();
      for (int c = 0; c < 16; c++) begin step("s3to"); tick(); end
      ramstate = 2'd2; halt = 1;
      for (int c = 0; c < 4; c++) begin
         step("s3err"); chk("s3.merr_sticky", 32'(merr), 1); chk("s3.nohit", 32'(dhit), 0); tick();
      end

      // halt with a pending data read
      do_reset();
      halt = 1; dREN = 1; daddr = 32'h200; ramstate = 2'd2; ramload = 32'h0BAD_F00D;
      step("s4c1"); tick();
      step("s4c2"); chk("s4.dhit", 32'(dhit), 1); tick();
      dREN = 0;
      step("s4c3"); tick();
      iREN = 1; iaddr = 32'h300;
      for (int c = 0; c < 3; c++) begin
         step("s4halt"); chk("s4.halted", 32'(halted), 1); chk("s4.noren", 32'(ramREN), 0); tick();
      end

      // fetch abort keeps data priority, then ERROR during data grant
      do_reset();
      iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
      step("s5c1"); tick();
      step("s5c2"); chk("s5.ren", 32'(ramREN), 1); tick();
      iREN = 0;
      step("s5abort"); chk("s5.abort_ren", 32'(ramREN), 0); chk("s5.abort_hit", 32'(ihit), 0); tick();
      iREN = 1; dREN = 1; daddr = 32'h88;
      step("s5tie"); tick();
      ramstate = 2'd3;
      step("s5d"); chk("s5.daddr", ramaddr, 32'h88); chk("s5.noerrhit", 32'(dhit), 0); tick();
      step("s5err"); chk("s5.merr", 32'(merr), 1); tick();

      // async reset in the middle of a grant
      do_reset();
      iREN = 1; iaddr = 32'h60; ramstate = 2'd1;
      step("s6c1"); tick();
      step("s6c2"); chk("s6.ren", 32'(ramREN), 1);
      nRST = 1'b0; model_reset();
      #1; chk("s6.async_ren", 32'(ramREN), 0); chk("s6.async_hit", 32'(ihit), 0);
      @(negedge CLK); nRST = 1'b1;
      iREN = 0;

      // randomized traffic
      do_reset();
      term_cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         if (m_err || m_halt) term_cnt++;
         if (term_cnt > 3) begin do_reset(); term_cnt = 0; end
         r = $urandom_range(0, 99);
         ramstate = (r < 45) ? 2'd2 : (r < 85) ? 2'd1 : (r < 98) ? 2'd0 : 2'd3;
         ramload = $urandom; dstore = $urandom;
         iaddr = {$urandom} & 32'hFFFF_FFFC; daddr = $urandom;
         if (!iREN) iREN = ($urandom_range(0, 2) == 0);
         else if ($urandom_range(0, 19) == 0) iREN = 0;
         if (!(dREN | dWEN)) begin
            r = $urandom_range(0, 5);
            dREN = (r == 0) || (r == 2);
            dWEN = (r == 1) || (r == 2);
         end else if ($urandom_range(0, 19) == 0) begin
            dREN = 0; dWEN = 0;
         end
         if (!halt) halt = ($urandom_range(0, 149) == 0);
         step("rnd");
         clr_i = e_ihit; clr_d = e_dhit;
         tick();
         if (clr_i) iREN = 0;
         if (clr_d) begin dREN = 0; dWEN = 0; end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Shares the single-ported RAM between the datapath's instruction-fetch and data-access requests.
- Sequences each access as a registered grant FSM: alternating priority on conflicts, bounded wait via a timeout counter, sticky error reporting, and halt termination.
- Sits between the datapath (decode/PC/memory stage request lines) and the RAM controller.
- Returns ihit/dhit and load data to the datapath.

Parameters:
- ADDR_W, 32, width of instruction/data/RAM addresses
- DATA_W, 32, width of data words
- TIMEOUT, 15, max cycles a grant may wait for RAM ACCESS before an error is declared (1..255)

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction fetch request, held until ihit
- iaddr  in  ADDR_W  fetch address
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- halt  in  1  datapath decoded HALT
- ramload  in  DATA_W  RAM read data, valid when ramstate==ACCESS
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ihit  out  1  fetch complete, one-cycle pulse
- iload  out  DATA_W  fetched instruction, valid with ihit
- dhit  out  1  data access complete, one-cycle pulse
- dload  out  DATA_W  load data, valid with dhit
- merr  out  1  sticky memory error
- halted  out  1  arbiter has quiesced after halt

Behaviour:
- Reset (nRST low, async):
  - State IDLE, timeout counter 0, last_grant=INSTR (so the first tie goes to data).
  - All outputs 0.
- States: IDLE, IGRANT, DGRANT, ERR, HALTED. Registered state; RAM outputs and hits are combinational from state and inputs.
- IDLE:
  - RAM outputs all 0; ihit=dhit=0.
  - Data request = dREN|dWEN.
  - Data request and iREN both pending: grant the requester opposite last_grant.
  - Data request only: go to DGRANT.
  - iREN only, with halt=0: go to IGRANT.
  - No data request and halt=1: go to HALTED. A pending data request is always serviced before halting.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN=1: ramWEN=1, ramREN=0. Write wins if dREN and dWEN are both set.
  - Otherwise ramREN=1.
  - ramstate==ACCESS: dhit=1 and dload=ramload in that same cycle; last_grant<=DATA; go to IDLE.
- IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - ramstate==ACCESS: ihit=1 and iload=ramload in that same cycle; last_grant<=INSTR; go to IDLE.
- Latency:
  - Minimum access is 2 cycles: IDLE→grant, then ACCESS in the first grant cycle.
  - One IDLE bubble always follows each hit, so back-to-back hits are never on consecutive cycles.
- Abort: if the granted request drops before ACCESS (dREN=dWEN=0 in DGRANT, or iREN=0 in IGRANT), RAM enables deassert in that cycle, no hit is produced, and the FSM returns to IDLE. last_grant is unchanged.
- Timeout:
  - The counter clears on grant entry and increments each grant cycle without ACCESS.
  - At count==TIMEOUT with no ACCESS, go to ERR.
  - ramstate==ERROR in any grant state also goes to ERR immediately, with no hit.
- ERR:
  - merr=1, RAM enables 0, no hits.
  - Terminal until reset; halt is ignored.
- HALTED:
  - halted=1, RAM enables 0, no hits.
  - Terminal until reset; new requests are ignored.
- Load outputs:
  - iload/dload show ramload only while their hit is asserted; 0 otherwise.
  - They are not registered; the datapath captures them on the hit.
- Async reset mid-grant: outputs drop to 0 immediately. No partial hit is ever produced.

Test Plan:
- Reset then iREN=1, iaddr=0x0000_0040, ramstate ACCESS on first grant cycle → ramREN=1, ramaddr=0x40; ihit pulses cycle 2 with iload=ramload=0x3C01_0004; next cycle IDLE.
- iREN=1 and dWEN=1 together from reset (daddr=0x80, dstore=0xDEAD_BEEF) → data first: ramWEN=1, ramaddr=0x80, dhit; after the bubble, IGRANT serves the fetch. Holding both requests continuously alternates I/D grants.
- dREN=1 with ramstate BUSY for 3 cycles then ACCESS → dhit on 4th grant cycle, dload=ramload, merr=0. BUSY held 16 grant cycles with TIMEOUT=15 → ERR, merr=1 stays high with no hits until nRST.
- halt=1 while dREN pending in IDLE → DGRANT completes with dhit, then HALTED with halted=1; later iREN=1 gives ramREN=0.
- IGRANT with ramstate BUSY, then iREN drops → ramREN=0 in that cycle, no ihit, IDLE next; a following tie still prefers data (last_grant unchanged). ramstate ERROR in DGRANT → ERR with no dhit.
